toycpu_ctrl_fsm: RTL and testbench



---
 rtl/toycpu_pkg.sv | 25 ++
 rtl/toycpu_ctrl_fsm_if.sv | 23 ++
 rtl/toycpu_br_eval.sv | 11 +
 rtl/toycpu_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_toycpu_ctrl_fsm.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/toycpu_pkg.sv
// Shared opcode, next-PC-select and FSM state definitions for the toycpu
// multi-cycle control unit.
package toycpu_pkg;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b011;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_REL = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

endpackage

// File: rtl/toycpu_ctrl_fsm_if.sv
// Instruction-fetch and data-memory handshake bundle between the control
// unit (master) and the memories (slave).
interface toycpu_ctrl_fsm_if #(
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_ack;
  logic               mem_we;
  logic               daddr_sel;

  modport master (
    output imem_req, dmem_req, mem_we, daddr_sel,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, mem_we, daddr_sel,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/toycpu_br_eval.sv
// Branch condition: compare the selected ALU flag (zero or carry) against
// the expected value carried in the instruction.
module toycpu_br_eval (
  input  logic flag_sel_i,
  input  logic flag_val_i,
  input  logic c_flag_i,
  input  logic z_flag_i,
  output logic br_taken_o
);
  assign br_taken_o = (flag_val_i == (flag_sel_i ? z_flag_i : c_flag_i));
endmodule

// File: rtl/toycpu_ctrl_fsm.sv
// Multi-cycle toycpu control unit: fetches into IR, decodes, and sequences
// execute / memory / write-back phases with a retired-instruction counter.
module toycpu_ctrl_fsm
  import toycpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 2,
  parameter int IMM_W   = 8,
  parameter int ALU_W   = 7,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  toycpu_ctrl_fsm_if.master  bus,
  input  logic               c_flag,
  input  logic               z_flag,
  output logic               pc_en,
  output logic [1:0]         next_pc_sel,
  output logic               reg_we,
  output logic               reg_data_src,
  output logic               imm_data,
  output logic [REG_AW-1:0]  reg_dst,
  output logic [REG_AW-1:0]  reg_src1,
  output logic [REG_AW-1:0]  reg_src2,
  output logic [ALU_W-1:0]   alu_op,
  output logic [DATA_W-1:0]  instr_data,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               br_taken_q;
  logic [CNT_W-1:0]   retired_q;
  logic               br_taken;
  logic               retire;

  logic [2:0]       opcode;
  logic [IMM_W-1:0] payload;

  assign opcode   = ir_q[INSTR_W-1 -: 3];
  assign reg_dst  = ir_q[INSTR_W-4 -: REG_AW];
  assign reg_src1 = ir_q[INSTR_W-4-REG_AW -: REG_AW];
  assign reg_src2 = ir_q[INSTR_W-4-2*REG_AW -: REG_AW];
  assign payload  = ir_q[IMM_W-1:0];
  assign alu_op   = ir_q[ALU_W-1:0];
  assign retired  = retired_q;

  toycpu_br_eval u_br_eval (
    .flag_sel_i (ir_q[INSTR_W-4]),
    .flag_val_i (ir_q[INSTR_W-5]),
    .c_flag_i   (c_flag),
    .z_flag_i   (z_flag),
    .br_taken_o (br_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      br_taken_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (state_q == S_FETCH && bus.imem_ack) ir_q <= bus.imem_rdata;
      if (state_q == S_DECODE) br_taken_q <= br_taken;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ALU, OP_LDI, OP_BR: state_d = S_EXEC;
          OP_LD, OP_ST:          state_d = S_MEM;
          OP_HALT:               state_d = S_HALT;
          default:               state_d = S_FETCH;
        endcase
      end
      S_EXEC:   state_d = S_FETCH;
      S_MEM:    if (bus.dmem_ack) state_d = (opcode == OP_ST) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.daddr_sel = 1'b0;
    pc_en         = 1'b0;
    next_pc_sel   = PCSEL_INC;
    reg_we        = 1'b0;
    reg_data_src  = 1'b0;
    imm_data      = 1'b0;
    instr_data    = '0;
    halted        = 1'b0;
    illegal       = 1'b0;
    unique case (state_q)
      S_FETCH:  bus.imem_req = 1'b1;
      S_DECODE: begin
        case (opcode)
          OP_ALU, OP_LDI, OP_LD, OP_ST, OP_BR, OP_HALT: ;
          default: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        pc_en = 1'b1;
        case (opcode)
          OP_ALU: reg_we = 1'b1;
          OP_LDI: begin
            reg_we     = 1'b1;
            imm_data   = 1'b1;
            instr_data = {{(DATA_W-IMM_W){1'b0}}, payload};
          end
          OP_BR: begin
            if (br_taken_q) begin
              next_pc_sel = PCSEL_REL;
              instr_data  = {{(DATA_W-IMM_W){payload[IMM_W-1]}}, payload};
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.dmem_req  = 1'b1;
        bus.daddr_sel = 1'b1;
        bus.mem_we    = (opcode == OP_ST);
        // A store retires in the ack cycle itself; a load still needs WB.
        if (bus.dmem_ack && opcode == OP_ST) pc_en = 1'b1;
      end
      S_WB: begin
        reg_we        = 1'b1;
        reg_data_src  = 1'b1;
        bus.daddr_sel = 1'b1;
        pc_en         = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    retire = pc_en | (state_q == S_DECODE && opcode == OP_HALT);
  end

endmodule

// File: tb/tb_toycpu_ctrl_fsm.sv
// Directed bench for toycpu_ctrl_fsm: reset, ALU/LDI/BR/LD/ST sequencing,
// reset abort mid-store, illegal opcode and HALT.
module tb_toycpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_flag = 1'b0;
  logic        z_flag = 1'b0;
  logic        pc_en;
  logic [1:0]  next_pc_sel;
  logic        reg_we;
  logic        reg_data_src;
  logic        imm_data;
  logic [1:0]  reg_dst, reg_src1, reg_src2;
  logic [6:0]  alu_op;
  logic [15:0] instr_data;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_ret = '0;

  toycpu_ctrl_fsm_if #(.INSTR_W(16)) bus ();

  toycpu_ctrl_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .pc_en        (pc_en),
    .next_pc_sel  (next_pc_sel),
    .reg_we       (reg_we),
    .reg_data_src (reg_data_src),
    .imm_data     (imm_data),
    .reg_dst      (reg_dst),
    .reg_src1     (reg_src1),
    .reg_src2     (reg_src2),
    .alu_op       (alu_op),
    .instr_data   (instr_data),
    .halted       (halted),
    .illegal      (illegal),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  logic [56:0] all_o;
  assign all_o = {bus.imem_req, bus.dmem_req, bus.mem_we, bus.daddr_sel, pc_en, next_pc_sel,
                  reg_we, reg_data_src, imm_data, reg_dst, reg_src1, reg_src2, alu_op,
                  instr_data, halted, illegal, retired};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request, acks it with instr; returns in DECODE.
  task automatic fetch(input logic [15:0] instr);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 8) begin tick(); n++; end
    n_tests++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL fetch_timeout: imem_req=%b required 1", bus.imem_req);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = instr;
    tick();
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if (all_o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", all_o); end
    rst_n = 1'b1; exp_ret = '0;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %b required 0", bus.imem_req); end
    tick();
    n_tests++;
    if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_req: got %b required 1", bus.imem_req); end
  endtask

  task automatic test_alu();
    fetch(16'h0A85);
    n_tests++;
    if ({reg_dst, reg_src1, reg_src2, alu_op} !== {2'b01, 2'b01, 2'b01, 7'h05}) begin
      n_fail++; $display("FAIL alu_fields: got %b required %b", {reg_dst, reg_src1, reg_src2, alu_op}, {2'b01, 2'b01, 2'b01, 7'h05});
    end
    n_tests++;
    if ({reg_we, pc_en} !== 2'b00) begin n_fail++; $display("FAIL alu_decode_strobes: got %b required 00", {reg_we, pc_en}); end
    tick();
    n_tests++;
    if ({reg_we, pc_en, next_pc_sel} !== 4'b1100) begin
      n_fail++; $display("FAIL alu_exec_strobes: got %b required 1100", {reg_we, pc_en, next_pc_sel});
    end
    tick(); exp_ret++;
    n_tests++;
    if ({retired, reg_we, pc_en} !== {exp_ret, 2'b00}) begin
      n_fail++; $display("FAIL alu_retired: got %h required %h", {retired, reg_we, pc_en}, {exp_ret, 2'b00});
    end
  endtask

  task automatic test_ldi();
    fetch(16'h29F3);
    tick();
    n_tests++;
    if ({reg_we, imm_data, pc_en, instr_data} !== {3'b111, 16'h00F3}) begin
      n_fail++; $display("FAIL ldi_exec: got %h required %h", {reg_we, imm_data, pc_en, instr_data}, {3'b111, 16'h00F3});
    end
    tick(); exp_ret++;
    n_tests++;
    if (retired !== exp_ret) begin n_fail++; $display("FAIL ldi_retired: got %h required %h", retired, exp_ret); end
  endtask

  task automatic test_br(input logic z, input logic [1:0] exp_sel, input logic [15:0] exp_data);
    fetch(16'hD8FE);
    z_flag = z; c_flag = ~z;
    tick();
    z_flag = ~z; c_flag = z;
    #1;
    n_tests++;
    if ({pc_en, reg_we, next_pc_sel, instr_data} !== {2'b10, exp_sel, exp_data}) begin
      n_fail++; $display("FAIL br_z%0b: got %h required %h", z, {pc_en, reg_we, next_pc_sel, instr_data}, {2'b10, exp_sel, exp_data});
    end
    tick(); exp_ret++;
    z_flag = 1'b0; c_flag = 1'b0;
    n_tests++;
    if (retired !== exp_ret) begin n_fail++; $display("FAIL br_retired: got %h required %h", retired, exp_ret); end
  endtask

  task automatic test_ld();
    fetch(16'h6200);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin bus.dmem_ack = 1'b1; #1; end
      n_tests++;
      if ({bus.dmem_req, bus.daddr_sel, bus.mem_we, pc_en} !== 4'b1100) begin
        n_fail++; $display("FAIL ld_mem_cycle%0d: got %b required 1100", i, {bus.dmem_req, bus.daddr_sel, bus.mem_we, pc_en});
      end
    end
    tick();
    bus.dmem_ack = 1'b0;
    n_tests++;
    if ({reg_we, reg_data_src, bus.daddr_sel, pc_en, bus.dmem_req} !== 5'b11110) begin
      n_fail++; $display("FAIL ld_wb: got %b required 11110", {reg_we, reg_data_src, bus.daddr_sel, pc_en, bus.dmem_req});
    end
    tick(); exp_ret++;
    n_tests++;
    if (retired !== exp_ret) begin n_fail++; $display("FAIL ld_retired: got %h required %h", retired, exp_ret); end
  endtask

  task automatic test_st();
    fetch(16'hA000);
    tick();
    bus.dmem_ack = 1'b1;
    #1;
    n_tests++;
    if ({bus.dmem_req, bus.mem_we, bus.daddr_sel, pc_en, reg_we} !== 5'b11110) begin
      n_fail++; $display("FAIL st_ack: got %b required 11110", {bus.dmem_req, bus.mem_we, bus.daddr_sel, pc_en, reg_we});
    end
    tick(); exp_ret++;
    bus.dmem_ack = 1'b0;
    n_tests++;
    if ({retired, bus.imem_req} !== {exp_ret, 1'b1}) begin
      n_fail++; $display("FAIL st_retired: got %h required %h", {retired, bus.imem_req}, {exp_ret, 1'b1});
    end
  endtask

  task automatic test_st_reset();
    fetch(16'hA000);
    tick();
    n_tests++;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL st_abort_mem1: mem_we=%b required 1", bus.mem_we); end
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_o !== '0) begin n_fail++; $display("FAIL st_abort_async: got %h required 0", all_o); end
    tick(); tick();
    n_tests++;
    if (all_o !== '0) begin n_fail++; $display("FAIL st_abort_held: got %h required 0", all_o); end
    rst_n = 1'b1; exp_ret = '0;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL st_abort_idle: imem_req=%b required 0", bus.imem_req); end
    tick();
    n_tests++;
    if ({bus.imem_req, bus.mem_we} !== 2'b10) begin
      n_fail++; $display("FAIL st_abort_fetch: got %b required 10", {bus.imem_req, bus.mem_we});
    end
  endtask

  task automatic test_illegal_halt();
    fetch(16'h4000);
    n_tests++;
    if ({illegal, pc_en} !== 2'b11) begin n_fail++; $display("FAIL illegal_pulse: got %b required 11", {illegal, pc_en}); end
    tick(); exp_ret++;
    n_tests++;
    if ({illegal, bus.imem_req, retired} !== {2'b01, exp_ret}) begin
      n_fail++; $display("FAIL illegal_after: got %h required %h", {illegal, bus.imem_req, retired}, {2'b01, exp_ret});
    end
    fetch(16'hE000);
    n_tests++;
    if ({illegal, halted, pc_en} !== 3'b000) begin n_fail++; $display("FAIL halt_decode: got %b required 000", {illegal, halted, pc_en}); end
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    exp_ret++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({halted, bus.imem_req, bus.dmem_req, pc_en, illegal, retired} !== {5'b10000, exp_ret}) begin
        n_fail++; $display("FAIL halt_cycle%0d: got %h required %h", i,
                           {halted, bus.imem_req, bus.dmem_req, pc_en, illegal, retired}, {5'b10000, exp_ret});
      end
    end
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    n_tests++;
    if (retired !== 16'd2) begin n_fail++; $display("FAIL halt_retired: got %0d required 2", retired); end
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    test_reset();
    test_alu();
    test_ldi();
    test_br(1'b1, 2'b01, 16'hFFFE);
    test_br(1'b0, 2'b00, 16'h0000);
    test_ld();
    test_st();
    test_st_reset();
    test_illegal_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
